// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, start/busy/done handshake and divide-by-zero flag.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} stateT;

    stateT            state, stateNext;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] operand;
    logic             isDiv, negLo, negHi, divZeroPend;

    logic             accept, isSigned, aNeg, bNeg;
    logic [WIDTH-1:0] aMag, bMag;
    logic [WIDTH:0]   mulSum, remShift;
    logic [WIDTH-1:0] remDiff;
    logic             qBit;
    logic [2*WIDTH-1:0] mulNext, divNext, prodFix;
    logic [WIDTH-1:0] quotFix, remFix;

    // A start coinciding with the done pulse is deliberately not accepted.
    assign accept   = start && (state == IDLE) && !done;
    assign isSigned = ~op[0];
    assign aNeg     = isSigned & a[WIDTH-1];
    assign bNeg     = isSigned & b[WIDTH-1];
    assign aMag     = aNeg ? -a : a;
    assign bMag     = bNeg ? -b : b;

    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mulNext  = {mulSum, acc[WIDTH-1:1]};
        // Upper half holds the partial remainder, lower half shifts dividend out / quotient in.
        remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        qBit     = (remShift >= {1'b0, operand});
        remDiff  = remShift[WIDTH-1:0] - operand;
        divNext  = {(qBit ? remDiff : remShift[WIDTH-1:0]), acc[WIDTH-2:0], qBit};
        prodFix  = negLo ? -acc : acc;
        quotFix  = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix   = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = (op[1] && b == '0) ? FINISH : RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) stateNext = FINISH;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            operand     <= '0;
            isDiv       <= 1'b0;
            negLo       <= 1'b0;
            negHi       <= 1'b0;
            divZeroPend <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    isDiv       <= op[1];
                    divZeroPend <= op[1] && (b == '0);
                    operand     <= op[1] ? bMag : aMag;
                    acc         <= {{WIDTH{1'b0}}, (op[1] ? aMag : bMag)};
                    negLo       <= aNeg ^ bNeg;
                    negHi       <= op[1] ? aNeg : (aNeg ^ bNeg);
                    cnt         <= '0;
                    busy        <= 1'b1;
                    div_zero    <= 1'b0;
                end
                RUN: begin
                    acc <= isDiv ? divNext : mulNext;
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (divZeroPend) begin
                        div_zero <= 1'b1;
                    end else if (isDiv) begin
                        hi <= remFix;
                        lo <= quotFix;
                    end else begin
                        {hi, lo} <= prodFix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32): arithmetic,
// latency, handshake, divide-by-zero and mid-operation reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    int n, seen;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves any done cycle, issues one op, scrambles inputs during the run and
    // waits (bounded) for done; returns while done is high.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int expLat, input string tag);
        int cyc;
        tick;
        start = 1'b1; op = o; a = x; b = y;
        tick;
        start = 1'b0;
        chk({tag, " div_zero cleared at accept"}, {63'd0, div_zero}, 64'd0);
        if (expLat > 1) chk({tag, " busy at accept"}, {63'd0, busy}, 64'd1);
        a = $urandom; b = $urandom; op = 2'($urandom);
        cyc = 0;
        while (!done && cyc < 100) begin
            tick;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(expLat));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        tick; tick;
        reset = 1'b0;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset div_zero", {63'd0, div_zero}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);

        // MULT -3*5 with cycle-exact busy/done timing
        start = 1'b1; op = MULT; a = 32'hFFFF_FFFD; b = 32'd5;
        tick;
        start = 1'b0;
        chk("mult busy k", {63'd0, busy}, 64'd1);
        repeat (32) tick;
        chk("mult busy k+32", {63'd0, busy}, 64'd1);
        chk("mult no done k+32", {63'd0, done}, 64'd0);
        tick;
        chk("mult done k+33", {63'd0, done}, 64'd1);
        chk("mult busy low at done", {63'd0, busy}, 64'd0);
        chk("mult -3*5 hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult -3*5 lo", {32'd0, lo}, 64'hFFFF_FFF1);
        chk("mult div_zero", {63'd0, div_zero}, 64'd0);
        tick;
        chk("done one cycle", {63'd0, done}, 64'd0);
        chk("lo held", {32'd0, lo}, 64'hFFFF_FFF1);

        runOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "multu max");
        chk("multu max hi", {32'd0, hi}, 64'hFFFF_FFFE);
        chk("multu max lo", {32'd0, lo}, 64'h0000_0001);
        runOp(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mult -1*-1");
        chk("mult -1*-1 hi", {32'd0, hi}, 64'h0);
        chk("mult -1*-1 lo", {32'd0, lo}, 64'h1);
        runOp(MULT, 32'h8000_0000, 32'h8000_0000, 33, "mult min*min");
        chk("mult min*min hi", {32'd0, hi}, 64'h4000_0000);
        chk("mult min*min lo", {32'd0, lo}, 64'h0);

        runOp(DIV, 32'hFFFF_FFF9, 32'd2, 33, "div -7/2");
        chk("div -7/2 lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div -7/2 hi", {32'd0, hi}, 64'hFFFF_FFFF);
        runOp(DIV, 32'd7, 32'hFFFF_FFFE, 33, "div 7/-2");
        chk("div 7/-2 lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div 7/-2 hi", {32'd0, hi}, 64'h1);
        runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div min/-1");
        chk("div min/-1 lo", {32'd0, lo}, 64'h8000_0000);
        chk("div min/-1 hi", {32'd0, hi}, 64'h0);
        chk("div min/-1 div_zero", {63'd0, div_zero}, 64'd0);
        runOp(DIVU, 32'd7, 32'd2, 33, "divu 7/2");
        chk("divu 7/2 lo", {32'd0, lo}, 64'h3);
        chk("divu 7/2 hi", {32'd0, hi}, 64'h1);

        runOp(DIVU, 32'd7, 32'd0, 1, "divu by zero");
        chk("dz flag", {63'd0, div_zero}, 64'd1);
        chk("dz busy", {63'd0, busy}, 64'd0);
        chk("dz hi kept", {32'd0, hi}, 64'h1);
        chk("dz lo kept", {32'd0, lo}, 64'h3);
        tick;
        chk("dz flag held", {63'd0, div_zero}, 64'd1);
        runOp(MULT, 32'd2, 32'd3, 33, "mult after dz");
        chk("mult after dz lo", {32'd0, lo}, 64'h6);
        chk("mult after dz flag", {63'd0, div_zero}, 64'd0);

        // start held high across done: second op waits until one cycle after done
        tick;
        start = 1'b1; op = MULT; a = 32'd2; b = 32'd3;
        tick;
        start = 1'b0;
        repeat (4) tick;
        start = 1'b1; op = DIV; a = 32'd9; b = 32'd3;
        n = 0;
        while (!done && n < 100) begin
            tick;
            n++;
        end
        chk("hs first latency", 64'(n), 64'd29);
        chk("hs first lo", {32'd0, lo}, 64'h6);
        chk("hs first hi", {32'd0, hi}, 64'h0);
        tick;
        chk("hs start ignored at done", {63'd0, busy}, 64'd0);
        tick;
        chk("hs accepted after done", {63'd0, busy}, 64'd1);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            tick;
            n++;
        end
        chk("hs div latency", 64'(n), 64'd33);
        chk("hs div lo", {32'd0, lo}, 64'h3);
        chk("hs div hi", {32'd0, hi}, 64'h0);

        // reset in the middle of a divide
        tick;
        start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midreset busy", {63'd0, busy}, 64'd0);
        chk("midreset hi", {32'd0, hi}, 64'h0);
        chk("midreset lo", {32'd0, lo}, 64'h0);
        seen = 0;
        repeat (40) begin
            tick;
            if (done) seen++;
        end
        chk("midreset no done", 64'(seen), 64'd0);
        runOp(MULTU, 32'd7, 32'd6, 33, "after reset");
        chk("after reset lo", {32'd0, lo}, 64'h2A);
        chk("after reset hi", {32'd0, hi}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the multicycle datapath. It performs signed and unsigned multiply and divide on WIDTH-bit operands. It delivers a 2*WIDTH result split into hi/lo, which the control FSM loads into the High/Low registers. The unit uses a start/busy/done handshake and flags divide-by-zero, replacing the separate fixed-32-bit multiplier and divider.

Parameters:
WIDTH, 32, operand width and width of each of hi/lo; must be >= 4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only while idle
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: hi/lo/div_zero valid
div_zero  output  1  DIV/DIVU with b==0; valid with done and held until next accepted start
hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient

Behaviour:
- Clock is clk. Reset is synchronous and active-high: reset sampled high at a rising edge puts the unit in IDLE. It also clears busy, done, div_zero, hi, lo and all internal registers to 0.
- Reset overrides any other activity, including reset asserted mid-operation. The in-flight operation is dropped and no done pulse is produced.
- States:
  - IDLE, RUN, FINISH.
  - IDLE -> RUN: start=1 at edge k.
    - At edge k the unit captures op, a and b.
    - For signed ops it stores the operand magnitudes and the result signs. The product sign is a_msb^b_msb. The quotient sign is a_msb^b_msb. The remainder sign is a_msb.
    - It clears the iteration counter, sets busy=1 and clears div_zero.
  - IDLE -> FINISH (divide-by-zero): start at edge k with op[1]=1 and b==0.
    - At edge k+1, done=1, div_zero=1 and busy=0.
    - hi and lo keep their previous values.
  - RUN:
    - Runs for exactly WIDTH iterations, one per edge, at edges k+1..k+WIDTH.
    - Multiply is radix-2 shift-add on unsigned magnitudes into a 2*WIDTH accumulator.
    - Divide is restoring: shift the remainder left, subtract the divisor, and keep the subtraction if it is non-negative (quotient bit 1).
  - RUN -> FINISH after the WIDTH-th iteration.
  - FINISH -> IDLE at edge k+WIDTH+1.
    - Apply two's-complement sign correction, then write hi/lo.
    - done=1 for exactly that one cycle and busy=0 from that same edge.
- Latency: for normal ops, done is high in the cycle after edge k+WIDTH+1 (WIDTH+1 edges after accept; 33 for WIDTH=32). For divide-by-zero, done is high after edge k+1.
- start while busy=1 is ignored with no side effects. start in the same cycle as done is also ignored; it is accepted once the unit is back in IDLE, one cycle later.
- hi, lo and div_zero hold their values from done until the next accepted start. A new start does not clear hi/lo until the new FINISH.
- Arithmetic rules:
  - Signed divide truncates toward zero. The remainder takes the dividend's sign, and |rem| < |b|.
  - Signed overflow case DIV MIN/-1: lo=MIN, hi=0, div_zero=0, no flag raised.
  - Signed MULT of MIN*MIN gives the exact 2*WIDTH product.
  - Unsigned ops use raw bit patterns with no sign correction.
- Changes on a, b or op during RUN have no effect.

Test Plan:
- MULT a=FFFFFFFD (-3), b=00000005, start at edge k -> busy=1 for edges k..k+32. done pulses one cycle after edge k+33 with hi=FFFFFFFF, lo=FFFFFFF1, div_zero=0.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. MULT on the same operands -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIVU a=00000007, b=00000002 -> lo=3, hi=1. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- DIVU a=7, b=0 at edge k -> done and div_zero=1 after edge k+1. hi/lo keep their previous results. A following MULT 2*3 clears div_zero at accept and ends with lo=6.
- Handshake: issue MULT 2*3, then pulse start with DIV 9/3 at edge k+5 and hold start high through the done cycle. The first done gives lo=6 only. The DIV is accepted one cycle after done, and its own done arrives 33 edges later with lo=3, hi=0.
- Reset mid-op: assert reset at edge k+10 of a DIV -> busy=0, hi=lo=0, no done pulse. A new start after reset completes normally.
